// File: rtl/read_data_packer_pkg.sv
// read_data_packer_pkg: shared constants and FSM state type for the read return path.
package read_data_packer_pkg;
   localparam int BACKEND_WORD_SIZE = 32;
   localparam int READ_BEATS        = 4;
   typedef enum logic [1:0] {IDLE, COLLECT, RESP} rd_state_t;
endpackage

// File: rtl/rsp_tag_fifo.sv
// rsp_tag_fifo: small synchronous FIFO of read IDs with extra-MSB pointers for full/empty.
module rsp_tag_fifo #(
   parameter int ID_WIDTH  = 4,
   parameter int TAG_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic                pop,
   input  logic [ID_WIDTH-1:0] din,
   output logic [ID_WIDTH-1:0] head,
   output logic                full,
   output logic                empty,
   output logic [TAG_DEPTH:0]  count
);
   logic [ID_WIDTH-1:0] mem [2**TAG_DEPTH];
   logic [TAG_DEPTH:0]  wr_ptr, rd_ptr;
   logic                wr_en, rd_en;
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign count = wr_ptr - rd_ptr;
   assign empty = wr_ptr == rd_ptr;
   assign full  = (wr_ptr[TAG_DEPTH] != rd_ptr[TAG_DEPTH]) &&
                  (wr_ptr[TAG_DEPTH-1:0] == rd_ptr[TAG_DEPTH-1:0]);
   assign head  = mem[rd_ptr[TAG_DEPTH-1:0]];
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end
   always_ff @(posedge clk) if (wr_en) mem[wr_ptr[TAG_DEPTH-1:0]] <= din;
endmodule

// File: rtl/read_data_packer.sv
// read_data_packer: packs BEATS backend read words into one frontend response tagged
// with the read ID queued by the command path, returned over valid/ready.
module read_data_packer import read_data_packer_pkg::*; #(
   parameter int DATA_WIDTH = BACKEND_WORD_SIZE,
   parameter int BEATS      = READ_BEATS,
   parameter int ID_WIDTH   = 4,
   parameter int TAG_DEPTH  = 2
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_req_valid,
   input  logic [ID_WIDTH-1:0]         i_req_id,
   output logic                        o_req_ready,
   input  logic [DATA_WIDTH-1:0]       i_fifo_data,
   input  logic                        i_fifo_empty,
   output logic                        o_fifo_rd_en,
   output logic                        o_rsp_valid,
   output logic [BEATS*DATA_WIDTH-1:0] o_rsp_data,
   output logic [ID_WIDTH-1:0]         o_rsp_id,
   input  logic                        i_rsp_ready,
   output logic                        o_busy
);
   localparam int CW = $clog2(BEATS);
   localparam logic [TAG_DEPTH:0] ONE_TAG = 1;
   rd_state_t                          state, state_nxt;
   logic [CW-1:0]                      beat_cnt;
   logic [BEATS-1:0][DATA_WIDTH-1:0]   pack;
   logic [ID_WIDTH-1:0]                tag_head;
   logic [TAG_DEPTH:0]                 tag_count;
   logic                               tag_full, tag_empty, push, hs;

   assign o_req_ready = !tag_full;
   assign push        = i_req_valid && o_req_ready;
   assign hs          = o_rsp_valid && i_rsp_ready;

   rsp_tag_fifo #(.ID_WIDTH(ID_WIDTH), .TAG_DEPTH(TAG_DEPTH)) u_tag_fifo (
      .clk   (i_clk),
      .rst   (i_rst),
      .push  (push),
      .pop   (hs),
      .din   (i_req_id),
      .head  (tag_head),
      .full  (tag_full),
      .empty (tag_empty),
      .count (tag_count)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    state_nxt = tag_empty ? IDLE : COLLECT;
         COLLECT: state_nxt = (o_fifo_rd_en && beat_cnt == CW'(BEATS-1)) ? RESP : COLLECT;
         // a push landing on the last handshake keeps the pipeline collecting
         RESP:    state_nxt = !i_rsp_ready ? RESP : (tag_count != ONE_TAG || push) ? COLLECT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_fifo_rd_en = state == COLLECT && !i_fifo_empty;
      o_rsp_valid  = state == RESP;
      o_rsp_id     = o_rsp_valid ? tag_head : '0;
      o_rsp_data   = pack;
      o_busy       = state != IDLE || !tag_empty;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         beat_cnt <= '0;
         pack     <= '0;
      end else if (o_fifo_rd_en) begin
         pack[beat_cnt] <= i_fifo_data;
         beat_cnt       <= beat_cnt + 1'b1;
      end
   end
endmodule
